// File: rtl/ctrl_unit_pkg.sv
// Shared encodings for the 16-bit processor control unit: opcodes, FSM states,
// instruction field positions and the RF-source / ALU select codes.
package ctrl_unit_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_LDI   = 4'd6,
        OP_JMP   = 4'd7,
        OP_JZ    = 4'd8
    } opcode_e;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_HALT   = 4'd8,
        ST_SUB    = 4'd9,
        ST_LDI    = 4'd10,
        ST_JMP    = 4'd11,
        ST_JZ     = 4'd12
    } state_e;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 12;
    localparam int unsigned FA_HI  = 11;
    localparam int unsigned FA_LO  = 8;
    localparam int unsigned FB_HI  = 7;
    localparam int unsigned FB_LO  = 4;
    localparam int unsigned FC_HI  = 3;
    localparam int unsigned FC_LO  = 0;
    localparam int unsigned IMM_HI = 11;
    localparam int unsigned IMM_LO = 4;
    localparam int unsigned DA_HI  = 7;
    localparam int unsigned DA_LO  = 0;

    localparam logic [1:0] RFS_ALU  = 2'b00;
    localparam logic [1:0] RFS_DMEM = 2'b01;
    localparam logic [1:0] RFS_IMM  = 2'b10;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/ctrl_unit_param_if.sv
// Bundle of instruction-memory, datapath-control and debug signals between
// the control unit (master) and the ROM/datapath side (slave).
interface ctrl_unit_param_if #(
    parameter int unsigned PC_W    = 7,
    parameter int unsigned DADDR_W = 8
);
    logic [15:0]        IMem_Q;
    logic               Ra_Zero;
    logic               Run;
    logic [PC_W-1:0]    IMem_Addr;
    logic [PC_W-1:0]    PC_Out;
    logic [15:0]        IR_Out;
    logic [DADDR_W-1:0] D_Addr;
    logic               D_Wr;
    logic [1:0]         RF_s;
    logic [15:0]        RF_Imm;
    logic [3:0]         RF_W_Addr;
    logic               RF_W_en;
    logic [3:0]         RF_Ra_Addr;
    logic [3:0]         RF_Rb_Addr;
    logic [2:0]         ALU_s0;
    logic [3:0]         outState;
    logic [3:0]         nextState;

    modport master (
        input  IMem_Q, Ra_Zero, Run,
        output IMem_Addr, PC_Out, IR_Out, D_Addr, D_Wr, RF_s, RF_Imm,
               RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0,
               outState, nextState
    );

    modport slave (
        output IMem_Q, Ra_Zero, Run,
        input  IMem_Addr, PC_Out, IR_Out, D_Addr, D_Wr, RF_s, RF_Imm,
               RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0,
               outState, nextState
    );
endinterface

// File: rtl/ctrl_unit_param_pc_reg.sv
// Program counter: synchronous active-low clear, load (jump) and wrapping
// increment; a load takes priority over the increment.
module pc_reg #(
    parameter int unsigned PC_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            ld,
    input  logic [PC_W-1:0] ld_val,
    output logic [PC_W-1:0] pc
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (ld) begin
            pc_d = ld_val;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/ctrl_unit_param.sv
// Control unit: PC, IR and the fetch/decode/execute FSM; all control lines are
// Moore decodes of the registered state and IR.
module ctrl_unit_param
    import ctrl_unit_pkg::*;
#(
    parameter int unsigned PC_W     = 7,
    parameter int unsigned DADDR_W  = 8,
    parameter int unsigned IMEM_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    ctrl_unit_param_if.master bus
);
    localparam int unsigned CNT_W = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_LAT - 1);

    state_e          state_q, state_d;
    logic [15:0]     ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            pc_inc;
    logic            pc_ld;
    logic [PC_W-1:0] pc_val;

    pc_reg #(.PC_W(PC_W)) u_pc (
        .clk    (Clk),
        .rst_n  (Reset),
        .inc    (pc_inc),
        .ld     (pc_ld),
        .ld_val (ir_q[PC_W-1:0]),
        .pc     (pc_val)
    );

    // Next-state, IR capture and PC control.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        case (state_q)
            ST_INIT: begin
                cnt_d   = '0;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (cnt_q == CNT_LAST) begin
                    ir_d    = bus.IMem_Q;
                    pc_inc  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DECODE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                case (ir_q[OPC_HI:OPC_LO])
                    OP_NOOP:  state_d = ST_NOOP;
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOAD_A;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    OP_LDI:   state_d = ST_LDI;
                    OP_JMP:   state_d = ST_JMP;
                    OP_JZ:    state_d = ST_JZ;
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_HALT: begin
                if (bus.Run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_JMP: begin
                pc_ld   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_JZ: begin
                pc_ld   = bus.Ra_Zero;
                state_d = ST_FETCH;
            end
            ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB, ST_LDI: begin
                state_d = ST_FETCH;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_INIT;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [DADDR_W-1:0] d_addr;
    logic               d_wr;
    logic [1:0]         rf_s;
    logic [3:0]         rf_w_addr;
    logic               rf_w_en;
    logic [3:0]         rf_ra_addr;
    logic [3:0]         rf_rb_addr;
    logic [2:0]         alu_s0;

    // Datapath control decode; everything idles at zero outside its state.
    always_comb begin
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = RFS_ALU;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s0     = ALU_PASS;
        case (state_q)
            ST_ADD, ST_SUB: begin
                rf_ra_addr = ir_q[FA_HI:FA_LO];
                rf_rb_addr = ir_q[FB_HI:FB_LO];
                rf_w_addr  = ir_q[FC_HI:FC_LO];
                rf_w_en    = 1'b1;
                alu_s0     = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            ST_LOAD_A: begin
                d_addr = DADDR_W'(ir_q[IMM_HI:IMM_LO]);
                rf_s   = RFS_DMEM;
            end
            ST_LOAD_B: begin
                d_addr    = DADDR_W'(ir_q[IMM_HI:IMM_LO]);
                rf_s      = RFS_DMEM;
                rf_w_addr = ir_q[FC_HI:FC_LO];
                rf_w_en   = 1'b1;
            end
            ST_STORE: begin
                rf_ra_addr = ir_q[FA_HI:FA_LO];
                d_addr     = DADDR_W'(ir_q[DA_HI:DA_LO]);
                d_wr       = 1'b1;
            end
            ST_LDI: begin
                rf_s      = RFS_IMM;
                rf_w_addr = ir_q[FC_HI:FC_LO];
                rf_w_en   = 1'b1;
            end
            ST_JZ: begin
                rf_ra_addr = ir_q[FA_HI:FA_LO];
            end
            default: begin
            end
        endcase
    end

    assign bus.IMem_Addr  = pc_val;
    assign bus.PC_Out     = pc_val;
    assign bus.IR_Out     = ir_q;
    assign bus.D_Addr     = d_addr;
    assign bus.D_Wr       = d_wr;
    assign bus.RF_s       = rf_s;
    assign bus.RF_Imm     = {8'h00, ir_q[IMM_HI:IMM_LO]};
    assign bus.RF_W_Addr  = rf_w_addr;
    assign bus.RF_W_en    = rf_w_en;
    assign bus.RF_Ra_Addr = rf_ra_addr;
    assign bus.RF_Rb_Addr = rf_rb_addr;
    assign bus.ALU_s0     = alu_s0;
    assign bus.outState   = state_q;
    assign bus.nextState  = state_d;
endmodule

// File: tb/tb_ctrl_unit_param.sv
// Bench for ctrl_unit_param: a scoreboard of expected execute-state outputs for
// a small program, plus direct checks of reset, fetch latency, HALT and wrap.
module tb_ctrl_unit_param;
    import ctrl_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ctrl_unit_param_if #(.PC_W(7), .DADDR_W(8)) b1 ();
    ctrl_unit_param_if #(.PC_W(7), .DADDR_W(8)) b3 ();

    ctrl_unit_param #(.PC_W(7), .DADDR_W(8), .IMEM_LAT(1)) dut1 (
        .Clk(clk), .Reset(rst_n), .bus(b1.master)
    );
    ctrl_unit_param #(.PC_W(7), .DADDR_W(8), .IMEM_LAT(3)) dut3 (
        .Clk(clk), .Reset(rst_n), .bus(b3.master)
    );

    logic [15:0] rom  [0:127];
    logic [15:0] rom3 [0:127];
    logic        run;

    assign b1.IMem_Q  = rom[b1.IMem_Addr];
    assign b1.Ra_Zero = (b1.PC_Out == 7'd9);
    assign b1.Run     = run;
    assign b3.IMem_Q  = rom3[b3.IMem_Addr];
    assign b3.Ra_Zero = 1'b0;
    assign b3.Run     = run;

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  pc;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  w;
        logic        wen;
        logic [1:0]  rfs;
        logic [2:0]  alu;
        logic [7:0]  daddr;
        logic        dwr;
        logic [15:0] imm;
        logic [3:0]  nxt;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic        started  = 1'b0;
    logic [3:0]  prev_state = 4'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] st, input logic [6:0] pc,
                            input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] w,
                            input logic wen, input logic [1:0] rfs, input logic [2:0] alu,
                            input logic [7:0] daddr, input logic dwr, input logic [15:0] imm,
                            input logic [3:0] nxt);
        exp_t e;
        e = '{st: st, pc: pc, ra: ra, rb: rb, w: w, wen: wen, rfs: rfs, alu: alu,
              daddr: daddr, dwr: dwr, imm: imm, nxt: nxt};
        sb.push_back(e);
    endtask

    function automatic logic is_exec(input logic [3:0] s);
        return (s >= 4'd3) && (s <= 4'd12);
    endfunction

    task automatic wait_state(input logic [3:0] st, input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (b1.outState != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(b1.outState), 32'(st));
    endtask

    task automatic wait_pc(input logic [6:0] pc, input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (b1.PC_Out != pc && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(b1.PC_Out), 32'(pc));
    endtask

    // Execute-state monitor for dut1 plus idle checks on the write strobes.
    always @(negedge clk) begin
        if (started) begin
            if (b1.outState != ST_STORE)
                check_eq("dwr_idle", 32'(b1.D_Wr), 32'(0));
            if (!(b1.outState inside {ST_ADD, ST_SUB, ST_LOAD_B, ST_LDI}))
                check_eq("wen_idle", 32'(b1.RF_W_en), 32'(0));
            if (is_exec(b1.outState) && b1.outState != prev_state) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'(sb.size()), 32'(1));
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("ex_state", 32'(b1.outState),   32'(mon_e.st));
                    check_eq("ex_pc",    32'(b1.PC_Out),     32'(mon_e.pc));
                    check_eq("ex_ra",    32'(b1.RF_Ra_Addr), 32'(mon_e.ra));
                    check_eq("ex_rb",    32'(b1.RF_Rb_Addr), 32'(mon_e.rb));
                    check_eq("ex_w",     32'(b1.RF_W_Addr),  32'(mon_e.w));
                    check_eq("ex_wen",   32'(b1.RF_W_en),    32'(mon_e.wen));
                    check_eq("ex_rfs",   32'(b1.RF_s),       32'(mon_e.rfs));
                    check_eq("ex_alu",   32'(b1.ALU_s0),     32'(mon_e.alu));
                    check_eq("ex_daddr", 32'(b1.D_Addr),     32'(mon_e.daddr));
                    check_eq("ex_dwr",   32'(b1.D_Wr),       32'(mon_e.dwr));
                    check_eq("ex_imm",   32'(b1.RF_Imm),     32'(mon_e.imm));
                    check_eq("ex_next",  32'(b1.nextState),  32'(mon_e.nxt));
                end
            end
        end
        prev_state = b1.outState;
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            rom[i]  = 16'h0000;
            rom3[i] = 16'h0000;
        end
        rom[7'h00] = 16'h3ABC;
        rom[7'h01] = 16'h4123;
        rom[7'h02] = 16'h7005;
        rom[7'h03] = 16'h2FFF;
        rom[7'h05] = 16'h2BC5;
        rom[7'h06] = 16'h1ABC;
        rom[7'h07] = 16'h6FF3;
        rom[7'h08] = 16'h8210;
        rom[7'h10] = 16'h8210;
        rom[7'h11] = 16'h5001;
        rom[7'h12] = 16'h707F;
        rom3[7'h00] = 16'h3ABC;

        // Second pass through the program is cut short by reset in LOAD_A.
        for (int p = 0; p < 2; p++) begin
            push_exp(4'd7,  7'h01, 4'hA, 4'hB, 4'hC, 1'b1, 2'b00, 3'b001, 8'h00, 1'b0, 16'h00AB, 4'd1);
            push_exp(4'd9,  7'h02, 4'h1, 4'h2, 4'h3, 1'b1, 2'b00, 3'b010, 8'h00, 1'b0, 16'h0012, 4'd1);
            push_exp(4'd11, 7'h03, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 3'b000, 8'h00, 1'b0, 16'h0000, 4'd1);
            push_exp(4'd4,  7'h06, 4'h0, 4'h0, 4'h0, 1'b0, 2'b01, 3'b000, 8'hBC, 1'b0, 16'h00BC, 4'd5);
            if (p == 0) begin
                push_exp(4'd5,  7'h06, 4'h0, 4'h0, 4'h5, 1'b1, 2'b01, 3'b000, 8'hBC, 1'b0, 16'h00BC, 4'd1);
                push_exp(4'd6,  7'h07, 4'hA, 4'h0, 4'h0, 1'b0, 2'b00, 3'b000, 8'hBC, 1'b1, 16'h00AB, 4'd1);
                push_exp(4'd10, 7'h08, 4'h0, 4'h0, 4'h3, 1'b1, 2'b10, 3'b000, 8'h00, 1'b0, 16'h00FF, 4'd1);
                push_exp(4'd12, 7'h09, 4'h2, 4'h0, 4'h0, 1'b0, 2'b00, 3'b000, 8'h00, 1'b0, 16'h0021, 4'd1);
                push_exp(4'd12, 7'h11, 4'h2, 4'h0, 4'h0, 1'b0, 2'b00, 3'b000, 8'h00, 1'b0, 16'h0021, 4'd1);
                push_exp(4'd8,  7'h12, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 3'b000, 8'h00, 1'b0, 16'h0000, 4'd8);
                push_exp(4'd11, 7'h13, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 3'b000, 8'h00, 1'b0, 16'h0007, 4'd1);
                push_exp(4'd3,  7'h00, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 3'b000, 8'h00, 1'b0, 16'h0000, 4'd1);
            end
        end

        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_state",  32'(b1.outState), 32'(0));
        check_eq("rst_pc",     32'(b1.PC_Out),   32'(0));
        check_eq("rst_ir",     32'(b1.IR_Out),   32'(0));
        check_eq("rst_dwr",    32'(b1.D_Wr),     32'(0));
        check_eq("rst_wen",    32'(b1.RF_W_en),  32'(0));
        check_eq("rst3_state", 32'(b3.outState), 32'(0));
        rst_n   = 1'b1;
        started = 1'b1;

        @(negedge clk);
        check_eq("st_fetch",  32'(b1.outState), 32'(1));
        begin
            int unsigned n = 0;
            while (b3.outState == ST_FETCH && n < 20) begin
                n++;
                @(negedge clk);
            end
            check_eq("lat3_fetch_cycles", 32'(n), 32'(3));
        end
        check_eq("lat3_decode", 32'(b3.outState), 32'(2));
        check_eq("lat3_pc",     32'(b3.PC_Out),   32'(1));
        check_eq("lat3_ir",     32'(b3.IR_Out),   32'(16'h3ABC));
        @(negedge clk);
        check_eq("lat3_add_st",  32'(b3.outState),   32'(7));
        check_eq("lat3_add_ra",  32'(b3.RF_Ra_Addr), 32'(4'hA));
        check_eq("lat3_add_rb",  32'(b3.RF_Rb_Addr), 32'(4'hB));
        check_eq("lat3_add_w",   32'(b3.RF_W_Addr),  32'(4'hC));
        check_eq("lat3_add_wen", 32'(b3.RF_W_en),    32'(1));
        check_eq("lat3_add_alu", 32'(b3.ALU_s0),     32'(1));
        check_eq("lat3_add_nxt", 32'(b3.nextState),  32'(1));

        wait_state(4'd8, 300, "reach_halt");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("halt_hold_st",  32'(b1.outState),  32'(8));
            check_eq("halt_hold_nxt", 32'(b1.nextState), 32'(8));
        end
        run = 1'b1;
        #1;
        check_eq("halt_run_nxt", 32'(b1.nextState), 32'(1));
        @(negedge clk);
        check_eq("resume_st", 32'(b1.outState), 32'(1));
        check_eq("resume_pc", 32'(b1.PC_Out),   32'(7'h12));

        wait_pc(7'h7F, 50, "reach_pc_7f");
        wait_state(4'd2, 20, "wrap_decode");
        check_eq("pc_wrap", 32'(b1.PC_Out), 32'(0));

        wait_state(4'd4, 50, "reach_load_a");
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_state", 32'(b1.outState), 32'(0));
        check_eq("abort_wen",   32'(b1.RF_W_en),  32'(0));
        check_eq("abort_pc",    32'(b1.PC_Out),   32'(0));
        repeat (3) @(negedge clk);
        check_eq("abort_hold",  32'(b1.outState), 32'(0));
        check_eq("sb_drained",  32'(sb.size()),   32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
